// File: rtl/cpu.sv
// Minimal multi-cycle 16-bit processor: FETCH/EXECUTE/HALT state machine over a
// unified 256-word instruction/data RAM with asynchronous read and synchronous write.

module cpu_ram (
    input  logic        clk,
    input  logic        i_we,
    input  logic [7:0]  i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata
);
    logic [15:0] memory [0:255];

    // Write port; contents survive reset so preloaded programs stay intact.
    always @(posedge clk) begin
        if (i_we) begin
            memory[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = memory[i_addr];
endmodule

module cpu (
    input  logic clk,
    input  logic rst
);
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Declaration values match reset values so the core runs from time 0 without a reset pulse.
    state_t      r_state  = S_FETCH;
    logic [7:0]  r_pc     = 8'h00;
    logic [15:0] r_ir     = 16'h0000;
    logic [15:0] r_regs [0:3] = '{default: 16'h0000};
    logic        r_halted = 1'b0;

    state_t      w_next_state;
    logic [3:0]  w_opcode;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic [15:0] w_rd_val;
    logic [15:0] w_rs_val;
    logic        w_mem_we;
    logic [7:0]  w_mem_addr;
    logic [15:0] w_mem_wdata;
    logic [15:0] w_mem_rdata;
    logic        w_reg_we;
    logic [15:0] w_reg_wdata;
    logic        w_branch;

    assign w_opcode = r_ir[15:12];
    assign w_rd     = r_ir[11:10];
    assign w_rs     = r_ir[9:8];
    assign w_imm    = r_ir[7:0];
    assign w_rd_val = r_regs[w_rd];
    assign w_rs_val = r_regs[w_rs];

    cpu_ram ram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = S_EXECUTE;
            S_EXECUTE: w_next_state = (w_opcode == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:    w_next_state = S_HALT;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Output decode: memory port, register write-back and branch control.
    always_comb begin
        w_mem_addr  = r_pc;
        w_mem_we    = 1'b0;
        w_mem_wdata = w_rd_val;
        w_reg_we    = 1'b0;
        w_reg_wdata = 16'h0000;
        w_branch    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_addr = r_pc;
            end
            S_EXECUTE: begin
                w_mem_addr = w_imm;
                case (w_opcode)
                    OP_LDI: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = {8'h00, w_imm};
                    end
                    OP_LD: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_mem_rdata;
                    end
                    OP_ST: begin
                        w_mem_we = ~r_halted;
                    end
                    OP_ADD: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_rd_val + w_rs_val;
                    end
                    OP_SUB: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_rd_val - w_rs_val;
                    end
                    OP_AND: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_rd_val & w_rs_val;
                    end
                    OP_OR: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_rd_val | w_rs_val;
                    end
                    OP_XOR: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_rd_val ^ w_rs_val;
                    end
                    OP_SHL: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = {w_rd_val[14:0], 1'b0};
                    end
                    OP_JMP: begin
                        w_branch = 1'b1;
                    end
                    OP_BEQZ: begin
                        w_branch = (w_rd_val == 16'h0000);
                    end
                    default: begin
                        w_branch = 1'b0;
                    end
                endcase
            end
            S_HALT: begin
                w_mem_addr = r_pc;
            end
            default: begin
                w_mem_addr = r_pc;
            end
        endcase
    end

    // Datapath registers: fetch loads IR and bumps PC; execute writes back and redirects PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= 8'h00;
            r_ir     <= 16'h0000;
            r_halted <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= w_mem_rdata;
                    r_pc <= r_pc + 8'd1;
                end
                S_EXECUTE: begin
                    if (w_reg_we) begin
                        r_regs[w_rd] <= w_reg_wdata;
                    end
                    if (w_branch) begin
                        r_pc <= w_imm;
                    end
                    if (w_opcode == OP_HALT) begin
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for cpu: expected RAM writes go into a queue that a monitor
// drains as the core issues stores; final RAM images are compared against a bench-side model.

module tb_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [23:0] exp_q [$];
    logic [15:0] exp_mem [0:255];

    cpu dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: each store the core presents must match the oldest expected store.
    always @(negedge clk) begin
        logic [23:0] e;
        if (dut.w_mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_store: got %h, expected no store",
                         {dut.w_mem_addr, dut.w_mem_wdata});
            end else begin
                e = exp_q.pop_front();
                check("store", {8'h00, dut.w_mem_addr, dut.w_mem_wdata}, {8'h00, e});
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) begin
            dut.ram.memory[i] = 16'hC000 + 16'(i);
            exp_mem[i]        = 16'hC000 + 16'(i);
        end
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [15:0] data);
        dut.ram.memory[addr] = data;
        exp_mem[addr]        = data;
    endtask

    task automatic expect_st(input logic [7:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
        exp_mem[addr] = data;
    endtask

    task automatic check_image(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.ram.memory[i] !== exp_mem[i]) begin
                bad++;
            end
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic begin_test();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        fill_mem();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] p4 [0:19] = '{
        16'h1001, 16'h5000, 16'h1401, 16'h5100, 16'h3083,
        16'h2C83, 16'h3C88, 16'h2890, 16'h9800, 16'h3884,
        16'h1C3C, 16'h8E00, 16'h3C85, 16'h140F, 16'h6700,
        16'h3486, 16'h1441, 16'h7700, 16'h3487, 16'hF000
    };

    initial begin
        // Power-up run: no reset pulse ever applied.
        fill_mem();
        load_word(8'h00, 16'h1005);
        load_word(8'h01, 16'h3080);
        expect_st(8'h80, 16'h0005);
        #1;
        check("pwrup_pc", 32'(dut.r_pc), 32'd0);
        check("pwrup_state", 32'(dut.r_state), 32'd0);
        edges(4);
        check("t1_mem80_edge4", 32'(dut.ram.memory[8'h80]), 32'h0005);
        edges(7);
        check("t1_pc", 32'(dut.r_pc), 32'd6);
        check("t1_r0", 32'(dut.r_regs[0]), 32'h0005);
        check_image("t1_image");
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // ADD then store then HALT; nothing may be written afterwards.
        begin_test();
        load_word(8'h00, 16'h1403);
        load_word(8'h01, 16'h1804);
        load_word(8'h02, 16'h4600);
        load_word(8'h03, 16'h3481);
        load_word(8'h04, 16'hF000);
        expect_st(8'h81, 16'h0007);
        #1;
        check("rst_pc", 32'(dut.r_pc), 32'd0);
        check("rst_ir", 32'(dut.r_ir), 32'd0);
        release_rst();
        edges(10);
        check("t2_pc_halt", 32'(dut.r_pc), 32'd5);
        check("t2_state_halt", 32'(dut.r_state), 32'd2);
        check("t2_halted", 32'(dut.r_halted), 32'd1);
        edges(55);
        check("t2_pc_hold", 32'(dut.r_pc), 32'd5);
        check("t2_mem81", 32'(dut.ram.memory[8'h81]), 32'h0007);
        check_image("t2_image");
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // BEQZ taken skips addr 2; then a NOP/JMP loop between addresses 7 and 8.
        begin_test();
        load_word(8'h00, 16'h1000);
        load_word(8'h01, 16'hB006);
        load_word(8'h02, 16'h1C01);
        load_word(8'h06, 16'h3C82);
        load_word(8'h07, 16'h0000);
        load_word(8'h08, 16'hA007);
        expect_st(8'h82, 16'h0000);
        release_rst();
        edges(10);
        check("t3_pc_jmp", 32'(dut.r_pc), 32'd7);
        edges(2);
        check("t3_pc_nop", 32'(dut.r_pc), 32'd8);
        edges(2);
        check("t3_pc_loop", 32'(dut.r_pc), 32'd7);
        check("t3_r3_skipped", 32'(dut.r_regs[3]), 32'd0);
        check("t3_mem82", 32'(dut.ram.memory[8'h82]), 32'h0000);
        check_image("t3_image");
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // SUB wrap, LD after ST, SHL carry-out, XOR/AND/OR.
        begin_test();
        for (int i = 0; i < 20; i++) begin
            load_word(8'(i), p4[i]);
        end
        load_word(8'h90, 16'h8001);
        expect_st(8'h83, 16'hFFFF);
        expect_st(8'h88, 16'hFFFF);
        expect_st(8'h84, 16'h0002);
        expect_st(8'h85, 16'h003E);
        expect_st(8'h86, 16'h000E);
        expect_st(8'h87, 16'h007F);
        release_rst();
        edges(50);
        check("t4_sub_wrap", 32'(dut.ram.memory[8'h83]), 32'hFFFF);
        check("t4_ld_after_st", 32'(dut.ram.memory[8'h88]), 32'hFFFF);
        check("t4_shl", 32'(dut.ram.memory[8'h84]), 32'h0002);
        check("t4_xor", 32'(dut.ram.memory[8'h85]), 32'h003E);
        check("t4_and", 32'(dut.ram.memory[8'h86]), 32'h000E);
        check("t4_or", 32'(dut.ram.memory[8'h87]), 32'h007F);
        check("t4_pc_halt", 32'(dut.r_pc), 32'd20);
        check_image("t4_image");
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // Store loop aborted by async reset during the third ST's execute cycle, run twice.
        begin_test();
        load_word(8'h00, 16'h1000);
        load_word(8'h01, 16'h1401);
        load_word(8'h02, 16'h4100);
        load_word(8'h03, 16'h30A0);
        load_word(8'h04, 16'hA002);
        for (int run = 0; run < 2; run++) begin
            expect_st(8'hA0, 16'h0001);
            expect_st(8'hA0, 16'h0002);
            release_rst();
            repeat (19) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("t5_async_pc", 32'(dut.r_pc), 32'd0);
            check("t5_async_r0", 32'(dut.r_regs[0]), 32'd0);
            check("t5_async_r1", 32'(dut.r_regs[1]), 32'd0);
            check("t5_async_state", 32'(dut.r_state), 32'd0);
            edges(10);
            check("t5_hold_pc", 32'(dut.r_pc), 32'd0);
            check("t5_memA0", 32'(dut.ram.memory[8'hA0]), 32'h0002);
            check_image("t5_image");
            check("t5_queue", 32'(exp_q.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
